xgmii_frame_checker: RTL and testbench

- Parametrised, synthesizable successor to the bench-only MII checker. Monitors an XGMII-style lane bus (DATA_WIDTH/8 byte lanes, one control bit per lane) and delineates frames.
- Checks each frame for preamble/SFD, length, inter-packet gap and control-character errors.
- Reports one registered status record per frame, plus saturating good/bad frame counters.
- Sits on the MAC→PCS transmit path (or any MII tap) as a passive monitor.

---
 rtl/xgmii_frame_checker.sv | 178 +++++++++++++++++
 tb/tb_xgmii_frame_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_frame_checker.sv
// Passive XGMII lane-bus monitor: delineates frames byte by byte and
// reports a registered per-frame status record plus good/bad counters.
module xgmii_frame_checker #(
  parameter int         DATA_WIDTH    = 64,
  parameter int         MIN_LEN       = 64,
  parameter int         MAX_LEN       = 1518,
  parameter int         MIN_IPG       = 12,
  parameter logic [7:0] IDLE_CODE     = 8'h07,
  parameter logic [7:0] START_CODE    = 8'hFB,
  parameter logic [7:0] TERM_CODE     = 8'hFD,
  parameter logic [7:0] PREAMBLE_CODE = 8'h55,
  parameter logic [7:0] SFD_CODE      = 8'hD5
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_tx_data,
  input  logic [DATA_WIDTH/8-1:0] i_tx_ctrl,
  output logic                    o_in_frame,
  output logic                    o_frame_done,
  output logic [15:0]             o_frame_len,
  output logic [4:0]              o_err_flags,
  output logic [31:0]             o_good_cnt,
  output logic [31:0]             o_bad_cnt
);

  localparam int NL = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA
  } state_t;

  state_t      state_q;
  state_t      state_n;
  logic [7:0]  ipg_q;
  logic [7:0]  ipg_n;
  logic [15:0] len_q;
  logic [15:0] len_n;
  logic [2:0]  pidx_q;
  logic [2:0]  pidx_n;
  logic        perr_q;
  logic        perr_n;
  logic        ierr_q;
  logic        ierr_n;

  logic        close_n;
  logic [15:0] flen_n;
  logic [4:0]  flags_n;
  logic        fpre;
  logic        fipg;
  logic        cerr;
  logic        tail;
  logic        skip;
  logic [7:0]  b;
  logic        c;

  function automatic logic [7:0] inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Walk the lanes in order; each lane sees the state left by the previous.
  always_comb begin
    state_n = state_q;
    ipg_n   = ipg_q;
    len_n   = len_q;
    pidx_n  = pidx_q;
    perr_n  = perr_q;
    ierr_n  = ierr_q;
    close_n = 1'b0;
    flen_n  = '0;
    fpre    = 1'b0;
    fipg    = 1'b0;
    cerr    = 1'b0;
    tail    = 1'b0;
    skip    = 1'b0;
    b       = '0;
    c       = 1'b0;
    for (int k = 0; k < NL; k++) begin
      b = i_tx_data[8*k +: 8];
      c = i_tx_ctrl[k];
      if (skip) begin
        b = b;
      end else if (tail) begin
        if (c && b == IDLE_CODE) begin
          ipg_n = inc8(ipg_n);
        end else begin
          cerr = 1'b1;
        end
      end else if (state_n == IDLE) begin
        if (c && b == IDLE_CODE) begin
          ipg_n = inc8(ipg_n);
        end else if (c && b == START_CODE && k == 0) begin
          ierr_n  = int'(ipg_n) < MIN_IPG;
          ipg_n   = '0;
          state_n = PREAMBLE;
          pidx_n  = '0;
          perr_n  = 1'b0;
          len_n   = '0;
        end
      end else if (c) begin
        close_n = 1'b1;
        flen_n  = len_n;
        fipg    = ierr_n;
        if (b == TERM_CODE) begin
          tail = 1'b1;
          fpre = perr_n | (state_n == PREAMBLE);
        end else begin
          // Abort: rest of the word is dropped, gap restarts from here.
          skip  = 1'b1;
          cerr  = 1'b1;
          ipg_n = '0;
          fpre  = perr_n;
        end
        state_n = IDLE;
      end else if (state_n == PREAMBLE) begin
        if (b != ((pidx_n == 3'd6) ? SFD_CODE : PREAMBLE_CODE)) begin
          perr_n = 1'b1;
        end
        if (pidx_n == 3'd6) begin
          state_n = DATA;
        end else begin
          pidx_n = pidx_n + 3'd1;
        end
      end else begin
        len_n = inc16(len_n);
      end
    end
    flags_n = {cerr, fipg,
               int'(flen_n) > MAX_LEN,
               int'(flen_n) < MIN_LEN,
               fpre};
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ipg_q        <= 8'hFF;
      len_q        <= '0;
      pidx_q       <= '0;
      perr_q       <= 1'b0;
      ierr_q       <= 1'b0;
      o_in_frame   <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_len  <= '0;
      o_err_flags  <= '0;
      o_good_cnt   <= '0;
      o_bad_cnt    <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_valid) begin
        state_q    <= state_n;
        ipg_q      <= ipg_n;
        len_q      <= len_n;
        pidx_q     <= pidx_n;
        perr_q     <= perr_n;
        ierr_q     <= ierr_n;
        o_in_frame <= state_n != IDLE;
        if (close_n) begin
          o_frame_done <= 1'b1;
          o_frame_len  <= flen_n;
          o_err_flags  <= flags_n;
          if (flags_n == 5'd0) begin
            if (o_good_cnt != '1) o_good_cnt <= o_good_cnt + 32'd1;
          end else begin
            if (o_bad_cnt != '1) o_bad_cnt <= o_bad_cnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xgmii_frame_checker.sv
// Scoreboard bench for xgmii_frame_checker: frames are described at the
// byte level, expected status is queued, a monitor checks each pulse.
module tb_xgmii_frame_checker;

  localparam int DW      = 64;
  localparam int NL      = DW / 8;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int MIN_IPG = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [DW-1:0] data;
  logic [NL-1:0] ctrl;
  logic          in_frame;
  logic          done;
  logic [15:0]   flen;
  logic [4:0]    flags;
  logic [31:0]   good_cnt;
  logic [31:0]   bad_cnt;

  xgmii_frame_checker #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_tx_data    (data),
    .i_tx_ctrl    (ctrl),
    .o_in_frame   (in_frame),
    .o_frame_done (done),
    .o_frame_len  (flen),
    .o_err_flags  (flags),
    .o_good_cnt   (good_cnt),
    .o_bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       c;
    logic [7:0] d;
    logic       open;
  } lane_t;

  typedef struct packed {
    logic [15:0] len;
    logic [4:0]  flags;
    logic [31:0] good;
    logic [31:0] bad;
  } exp_t;

  lane_t bq[$];
  exp_t  sb[$];
  int    tests = 0;
  int    fails = 0;
  int    good_m = 0;
  int    bad_m = 0;
  int    ipg_m = 255;
  int    stall_pct = 0;
  int    force_stall = -1;
  logic  last_open = 1'b0;

  task automatic chk(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic put(logic c, logic [7:0] d, logic open);
    lane_t l;
    l.c = c;
    l.d = d;
    l.open = open;
    bq.push_back(l);
  endtask

  task automatic stall_cycle();
    @(negedge clk);
    valid = 1'b0;
    data  = {$urandom, $urandom};
    ctrl  = NL'($urandom);
    @(posedge clk);
    #1;
    chk("stall_in_frame", in_frame, last_open);
  endtask

  task automatic send();
    lane_t l;
    int    w;
    w = 0;
    while (bq.size() > 0) begin
      if (w == force_stall) repeat (3) stall_cycle();
      if ($urandom_range(0, 99) < stall_pct) stall_cycle();
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        l = bq.pop_front();
        data[8*k +: 8] = l.d;
        ctrl[k] = l.c;
        last_open = l.open;
      end
      valid = 1'b1;
      @(posedge clk);
      #1;
      chk("in_frame", in_frame, last_open);
      w++;
    end
    force_stall = -1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // kind: 0 term, 1 abort (FE), 2 term inside preamble, 3 term + junk lane
  task automatic frame(int len, int pre_bad, int kind, int pre_n, int idle_words);
    logic [7:0] v;
    logic       pe;
    logic       ce;
    logic       ie;
    int         fl;
    int         npre;
    int         trail;
    int         idles;
    exp_t       e;
    pe = 1'b0;
    put(1'b1, 8'hFB, 1'b1);
    npre = (kind == 2) ? pre_n : 7;
    for (int i = 0; i < npre; i++) begin
      v = (i == 6) ? 8'hD5 : 8'h55;
      if (i == pre_bad) begin
        v = v ^ 8'h01;
        pe = 1'b1;
      end
      put(1'b0, v, 1'b1);
    end
    if (kind == 2) begin
      pe = 1'b1;
      fl = 0;
    end else begin
      fl = len;
      for (int i = 0; i < len; i++) put(1'b0, 8'($urandom), 1'b1);
    end
    ce = (kind == 1);
    put(1'b1, (kind == 1) ? 8'hFE : 8'hFD, 1'b0);
    trail = (NL - (bq.size() % NL)) % NL;
    idles = 0;
    for (int t = 0; t < trail; t++) begin
      if (kind == 3 && t == 0) begin
        put(1'b0, 8'h00, 1'b0);
        ce = 1'b1;
      end else begin
        put(1'b1, 8'h07, 1'b0);
        idles++;
      end
    end
    for (int i = 0; i < idle_words * NL; i++) put(1'b1, 8'h07, 1'b0);
    ie = ipg_m < MIN_IPG;
    ipg_m = ((kind == 1) ? 0 : idles) + idle_words * NL;
    if (ipg_m > 255) ipg_m = 255;
    e.len   = 16'(fl);
    e.flags = {ce, ie, fl > MAX_LEN, fl < MIN_LEN, pe};
    if (e.flags == 5'd0) good_m++;
    else bad_m++;
    e.good = 32'(good_m);
    e.bad  = 32'(bad_m);
    sb.push_back(e);
    send();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_in_frame"}, in_frame, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len"}, flen, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_good"}, good_cnt, 0);
    chk({tag, "_bad"}, bad_cnt, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("frame_len", flen, e.len);
        chk("err_flags", flags, e.flags);
        chk("good_cnt", good_cnt, e.good);
        chk("bad_cnt", bad_cnt, e.bad);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int ln;
    int kd;
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    ctrl  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    frame(64, -1, 0, 0, 1);
    frame(60, -1, 0, 0, 2);
    frame(64, -1, 0, 0, 1);
    frame(64, -1, 0, 0, 0);
    frame(64, -1, 0, 0, 2);
    frame(64, 3, 0, 0, 2);
    frame(18, -1, 1, 0, 2);
    chk("abort_idle", in_frame, 0);
    frame(0, -1, 2, 4, 2);
    frame(64, -1, 3, 0, 2);
    frame(1518, -1, 0, 0, 2);
    frame(1519, -1, 0, 0, 2);
    frame(63, -1, 0, 0, 2);

    put(1'b1, 8'hFB, 1'b1);
    for (int i = 0; i < 6; i++) put(1'b0, 8'h55, 1'b1);
    put(1'b0, 8'hD5, 1'b1);
    for (int i = 0; i < 24; i++) put(1'b0, 8'($urandom), 1'b1);
    send();
    chk("sb_empty_at_reset", sb.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    good_m = 0;
    bad_m = 0;
    ipg_m = 255;
    last_open = 1'b0;
    force_stall = 3;
    frame(64, -1, 0, 0, 2);

    stall_pct = 10;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) ln = $urandom_range(0, 63);
      else if (r == 1) ln = $urandom_range(1519, 1530);
      else ln = $urandom_range(64, 300);
      r = $urandom_range(0, 9);
      kd = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      frame(ln,
            ($urandom_range(0, 9) < 2) ? $urandom_range(0, 6) : -1,
            kd,
            $urandom_range(0, 6),
            $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
